// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial add sequencer.
package serial_adder_pkg;
    localparam int SA_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;
endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshakes and full-adder cell hookup for serial_adder.
// o_overflow exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_fa_bit1;
    logic             o_fa_bit2;
    logic             o_fa_cin;
    logic             i_fa_sum;
    logic             i_fa_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             o_overflow;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_fa_sum, i_fa_carry, i_ready,
        output o_ready, o_fa_bit1, o_fa_bit2, o_fa_cin, o_valid, o_sum, o_cout
`ifdef SERIAL_ADDER_OVF_EN
        , output o_overflow
`endif
    );

    modport master (
        output i_valid, i_a, i_b, i_cin, i_fa_sum, i_fa_carry, i_ready,
        input  o_ready, o_fa_bit1, o_fa_bit2, o_fa_cin, o_valid, o_sum, o_cout
`ifdef SERIAL_ADDER_OVF_EN
        , input o_overflow
`endif
    );
endinterface

// File: rtl/serial_shift_reg.sv
// WIDTH-bit right-shift register with parallel load; load wins over shift.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             shin_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i)
            q_d = load_val_i;
        else if (shift_i)
            q_d = WIDTH'({shin_i, q_q} >> 1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial add sequencer driving an external one-bit full-adder cell, LSB first.
// Optional signed-overflow output: define SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    serial_adder_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             accept, run, last;

    assign accept = (state_q == IDLE) && bus.i_valid;
    assign run    = (state_q == RUN);
    assign last   = run && (cnt_q == LAST);

    serial_shift_reg #(.WIDTH(WIDTH)) u_a (
        .i_clk(i_clk), .i_rst(i_rst), .load_i(accept), .load_val_i(bus.i_a),
        .shift_i(run), .shin_i(1'b0), .q_o(a_q)
    );
    serial_shift_reg #(.WIDTH(WIDTH)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .load_i(accept), .load_val_i(bus.i_b),
        .shift_i(run), .shin_i(1'b0), .q_o(b_q)
    );
    // Sum fills from the top, so after WIDTH shifts bit 0 sits at the LSB.
    serial_shift_reg #(.WIDTH(WIDTH)) u_sum (
        .i_clk(i_clk), .i_rst(i_rst), .load_i(accept), .load_val_i('0),
        .shift_i(run), .shin_i(bus.i_fa_sum), .q_o(sum_q)
    );

    logic unused_opnd_hi;
    assign unused_opnd_hi = ^{a_q, b_q};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = RUN;
            RUN:     if (last)        state_d = DONE;
            DONE:    if (bus.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        if (accept) begin
            cnt_d   = '0;
            carry_d = bus.i_cin;
        end else if (run) begin
            cnt_d   = cnt_q + CW'(1);
            carry_d = bus.i_fa_carry;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB; overflow is its disagreement with carry out of the MSB.
    logic carry_msb_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     carry_msb_q <= 1'b0;
        else if (last) carry_msb_q <= carry_q;
    end
`endif

    always_comb begin
        bus.o_ready   = 1'b0;
        bus.o_fa_bit1 = 1'b0;
        bus.o_fa_bit2 = 1'b0;
        bus.o_fa_cin  = 1'b0;
        bus.o_valid   = 1'b0;
        bus.o_sum     = '0;
        bus.o_cout    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        bus.o_overflow = 1'b0;
`endif
        case (state_q)
            IDLE: bus.o_ready = 1'b1;
            RUN: begin
                bus.o_fa_bit1 = a_q[0];
                bus.o_fa_bit2 = b_q[0];
                bus.o_fa_cin  = carry_q;
            end
            DONE: begin
                bus.o_valid = 1'b1;
                bus.o_sum   = sum_q;
                bus.o_cout  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
                bus.o_overflow = carry_msb_q ^ carry_q;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances with behavioural full adders.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
    serial_adder #(.WIDTH(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    assign bus.i_fa_sum    = bus.o_fa_bit1 ^ bus.o_fa_bit2 ^ bus.o_fa_cin;
    assign bus.i_fa_carry  = (bus.o_fa_bit1 & bus.o_fa_bit2) | (bus.o_fa_cin & (bus.o_fa_bit1 ^ bus.o_fa_bit2));
    assign bus1.i_fa_sum   = bus1.o_fa_bit1 ^ bus1.o_fa_bit2 ^ bus1.o_fa_cin;
    assign bus1.i_fa_carry = (bus1.o_fa_bit1 & bus1.o_fa_bit2) | (bus1.o_fa_cin & (bus1.o_fa_bit1 ^ bus1.o_fa_bit2));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t       e;
        logic [8:0] full;
        full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int n;
        n = 0;
        while (!bus.o_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {63'd0, bus.o_ready}, 64'd1);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        push_model(a, b, cin);
    endtask

    task automatic collect(input int lat, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {63'd0, bus.o_valid}, 64'd1);
            check("hold_ready", {63'd0, bus.o_ready}, 64'd0);
            check("hold_sum", {56'd0, bus.o_sum}, {56'd0, e.sum});
            @(posedge clk); #1;
        end
        check("sum", {56'd0, bus.o_sum}, {56'd0, e.sum});
        check("cout", {63'd0, bus.o_cout}, {63'd0, e.cout});
        check("fa_idle", {61'd0, bus.o_fa_bit1, bus.o_fa_bit2, bus.o_fa_cin}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("overflow", {63'd0, bus.o_overflow}, {63'd0, e.ovf});
`endif
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        check("post_valid", {63'd0, bus.o_valid}, 64'd0);
        check("post_ready", {63'd0, bus.o_ready}, 64'd1);
        check("post_sum", {56'd0, bus.o_sum}, 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_cin = 1'b0; bus.i_ready = 1'b0;
        bus1.i_valid = 1'b0; bus1.i_a = '0; bus1.i_b = '0; bus1.i_cin = 1'b0; bus1.i_ready = 1'b0;
        #12;
        check("rst_ready", {63'd0, bus.o_ready}, 64'd1);
        check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
        check("rst_sum", {55'd0, bus.o_cout, bus.o_sum}, 64'd0);
        check("rst_fa", {61'd0, bus.o_fa_bit1, bus.o_fa_bit2, bus.o_fa_cin}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        accept(8'h5A, 8'h3C, 1'b0);
        collect(8, 0);
        accept(8'hFF, 8'h01, 1'b0);
        collect(8, 0);
        accept(8'h00, 8'h00, 1'b1);
        collect(8, 0);
        accept(8'h7F, 8'h01, 1'b0);
        collect(8, 0);
        accept(8'hFF, 8'hFF, 1'b0);
        collect(8, 0);
        accept(8'h80, 8'h80, 1'b0);
        collect(8, 0);
        for (int i = 0; i < 4; i++) begin
            accept(8'($urandom), 8'($urandom), 1'($urandom));
            collect(8, 0);
        end

        // Backpressure with a competing request held during DONE
        accept(8'h12, 8'h34, 1'b1);
        bus.i_valid = 1'b1; bus.i_a = 8'hAA; bus.i_b = 8'h55; bus.i_cin = 1'b0;
        collect(8, 5);
        push_model(8'hAA, 8'h55, 1'b0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check("bp_accepted", {63'd0, bus.o_ready}, 64'd0);
        collect(8, 0);

        // Reset while bit 3 is on the cell
        accept(8'hFF, 8'hFF, 1'b0);
        sb.delete();
        repeat (3) begin @(posedge clk); #1; end
        check("mid_fa", {61'd0, bus.o_fa_bit1, bus.o_fa_bit2, bus.o_fa_cin}, 64'd7);
        rst = 1'b1;
        #1;
        check("abort_fa", {61'd0, bus.o_fa_bit1, bus.o_fa_bit2, bus.o_fa_cin}, 64'd0);
        check("abort_ready", {63'd0, bus.o_ready}, 64'd1);
        check("abort_valid", {63'd0, bus.o_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.o_valid) seen++;
            @(posedge clk); #1;
        end
        check("no_stale_result", 64'(seen), 64'd0);
        accept(8'h01, 8'h02, 1'b0);
        collect(8, 0);

        // WIDTH=1 instance: one RUN cycle
        bus1.i_valid = 1'b1; bus1.i_a = 1'b1; bus1.i_b = 1'b1; bus1.i_cin = 1'b1;
        @(posedge clk); #1;
        bus1.i_valid = 1'b0;
        n = 0;
        while (!bus1.o_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("w1_latency", 64'(n), 64'd1);
        check("w1_sum", {63'd0, bus1.o_sum}, 64'd1);
        check("w1_cout", {63'd0, bus1.o_cout}, 64'd1);
        bus1.i_ready = 1'b1;
        @(posedge clk); #1;
        bus1.i_ready = 1'b0;
        check("w1_idle", {62'd0, bus1.o_valid, bus1.o_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
